muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Accepts one operation per start pulse, keyed by instruction funct3 (funct7 = 0000001 is decoded upstream).
- Computes iteratively: shift-add for multiply, restoring division for divide.
- Reports completion with a one-cycle done pulse and holds the result until the next start.

Parameters:
- XLEN, 32, operand/result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(XLEN)+1, width of the internal iteration counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- kill  input  1  synchronous abort (pipeline flush).
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 operand (ReadData1).
- op_b  input  XLEN  rs2 operand (ReadData2).
- busy  output  1  high while an operation is in flight; the controller stalls the PC on it.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  operation result; held after done.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, counter=0; all operand/accumulator registers cleared. Applies immediately, including mid-operation; no done is produced for the aborted op.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at edge E0:
  - latch funct3, op_a, op_b;
  - record operand signs per op: MULH signs a and b; MULHSU signs a only; DIV/REM sign both; others unsigned;
  - convert signed operands to magnitudes; busy=1 after E0.
- Fast paths, checked at E0, go straight to FIN (done at E0+1):
  - divide by zero (op_b=0, funct3[2]=1): DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - signed overflow (DIV/REM, op_a=1 followed by XLEN-1 zeros, op_b=all ones): DIV = op_a; REM = 0.
- CALC: exactly XLEN iterations, one per cycle; counter counts XLEN-1 down to 0.
  - Multiply: 2*XLEN product register, add-and-shift on multiplier LSB.
  - Divide: XLEN+1-bit partial remainder, restoring subtract; quotient bit shifted in.
- Last iteration → FIN. Normal latency: start edge E0, done high during the cycle after edge E0+XLEN+1, i.e. XLEN+2 cycles start-to-done.
- FIN: sign correction applied when registering result.
  - product negated if the signs differ;
  - quotient negated if the signs differ;
  - remainder takes the sign of the dividend.
  - Result selection: MUL = low XLEN; MULH/MULHSU/MULHU = high XLEN; DIV/DIVU = quotient; REM/REMU = remainder.
  - done=1 for exactly one cycle, busy=0 in FIN; next state IDLE.
- result register updates only on FIN entry; stable otherwise, including across ignored starts.
- start while busy=1 or in FIN: ignored, no queueing.
- start coincident with the done cycle: ignored; a new op is accepted only in IDLE.
- kill=1 in CALC or FIN: next state IDLE, done suppressed, result unchanged; busy=0 next cycle. kill in IDLE has no effect; kill and start together in IDLE: kill wins, no op starts.
- op_a/op_b may change after E0 without effect.
- All arithmetic is modulo 2^XLEN on the output; no exceptions or flags.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 → busy=0, done=0, result=0; deassert rst → remains IDLE until start.
- MUL 7 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB, done exactly 34 cycles after the start edge (XLEN=32). MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Edge cases:
  - DIVU 5 / 0 → 0xFFFFFFFF with done one cycle after start;
  - REM 5 / 0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM on the same operands → 0.
- Abort and back-to-back:
  - kill at cycle 10 of a DIV → no done; busy falls next cycle; result keeps its previous value.
  - rst pulse mid-MUL → immediate IDLE, result 0.
  - start held high across the done cycle → second op begins only on the following IDLE edge.
- Parameter sweep XLEN=8: MUL 0x0F × 0x0F → 0xE1; MULHU → 0x00; DIV 0x80 / 0xFF → 0x80; latency 10 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Sign handling is done once on operand entry and once on result exit; the core iterates on magnitudes.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     b_mag_q;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN:0]       rem;
  logic [CNT_W-1:0]    cnt;
  logic                neg_res;
  logic                neg_rem;

  logic                sign_a, sign_b, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     fast_res;

  always_comb begin
    sign_a   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = sign_a & op_a[XLEN-1];
    b_neg    = sign_b & op_b[XLEN-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    fast_res = '0;
    if (div_zero)
      fast_res = funct3[1] ? op_a : '1;
    else
      fast_res = funct3[1] ? '0 : op_a;
  end

  // One iteration step: multiply adds then shifts right, divide shifts left then trial-subtracts.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_shift, trial;
  logic                ge;
  logic [XLEN:0]       rem_next;
  logic [XLEN-1:0]     quo_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_q} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    rem_shift = {rem[XLEN-1:0], acc[XLEN-1]};
    trial     = rem_shift - {1'b0, b_mag_q};
    ge        = rem[XLEN] | ~trial[XLEN];
    rem_next  = ge ? trial : rem_shift;
    quo_next  = {acc[XLEN-2:0], ge};
  end

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fin_res;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    fin_res  = '0;
    if (!f3_q[2])
      fin_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      fin_res = f3_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      f3_q    <= '0;
      b_mag_q <= '0;
      acc     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            f3_q    <= funct3;
            b_mag_q <= b_mag;
            acc     <= {{XLEN{1'b0}}, a_mag};
            rem     <= '0;
            cnt     <= CNT_W'(XLEN - 1);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (div_zero || div_ovf) begin
              result <= fast_res;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt[CNT_W-1]) begin
            // Counter has wrapped past zero: all XLEN iterations are in the registers.
            result <= fin_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FIN;
          end else begin
            if (f3_q[2]) begin
              acc <= {acc[2*XLEN-1:XLEN], quo_next};
              rem <= rem_next;
            end else begin
              acc <= mul_next;
            end
            cnt <= cnt - 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at XLEN=32 and XLEN=8
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  logic        start8 = 1'b0, kill8 = 1'b0;
  logic [2:0]  funct3_8 = '0;
  logic [7:0]  op_a8 = '0, op_b8 = '0;
  logic        busy8, done8;
  logic [7:0]  result8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .kill(kill8), .funct3(funct3_8),
    .op_a(op_a8), .op_b(op_b8), .busy(busy8), .done(done8), .result(result8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done32(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
  endtask

  task automatic run32(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; funct3 = ~f;
    wait_done32(n);
    check({tag, "_lat"}, n, lat);
    check(tag, result, exp);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  task automatic run8(input string tag, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int lat);
    int n;
    @(negedge clk);
    funct3_8 = f; op_a8 = a; op_b8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; op_a8 = 8'h5A; op_b8 = 8'h3C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 100);
    check({tag, "_lat"}, n, lat);
    check(tag, result8, exp);
  endtask

  initial begin
    int n;
    int seen;

    rst = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_result", result, 0);

    run32("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run32("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run32("mulh_n", 3'b001, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 34);
    run32("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run32("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34);
    run32("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
    run32("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
    run32("divu",   3'b101, 32'd100,      32'd7,        32'd14,        34);
    run32("remu",   3'b111, 32'd100,      32'd7,        32'd2,         34);

    // Abort a signed divide mid-flight; previous result (2) must survive.
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("kill_busy_before", busy, 1);
    kill = 1'b1;
    @(negedge clk);
    check("kill_busy_after", busy, 0);
    kill = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("kill_nodone", seen, 0);
    check("kill_hold", result, 2);

    run32("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run32("rem0",   3'b110, 32'd5,        32'd0,        32'd5,         1);
    run32("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run32("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Reset in the middle of a multiply clears everything immediately.
    run32("pre_rst", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    // Start held across the done cycle: next op starts only from IDLE.
    @(negedge clk);
    funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done32(n);
    check("held_lat", n, 34);
    check("held_first", result, 32'hFFFF_FFFE);
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);
    @(negedge clk);
    check("held_start_busy", busy, 1);
    start = 1'b0;
    wait_done32(n);
    check("held_second_lat", n, 33);
    check("held_second", result, 32'd42);

    run8("mul8",   3'b000, 8'h0F, 8'h0F, 8'hE1, 10);
    run8("mulhu8", 3'b011, 8'h0F, 8'h0F, 8'h00, 10);
    run8("div8",   3'b100, 8'h80, 8'hFF, 8'h80, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
